div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter DATA_W, default 32, SHALL be the operand width; the iteration count equals DATA_W.
REQ-002 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start_i  input  1  SHALL be the division request from EX, held high until ready_o is seen.
REQ-005 annul_i  input  1  SHALL abort the division in progress (flush/exception).
REQ-006 signed_i  input  1  SHALL select signed (1) or unsigned (0) division, sampled with start_i.
REQ-007 opdata1_i  input  DATA_W  SHALL be the dividend.
REQ-008 opdata2_i  input  DATA_W  SHALL be the divisor.
REQ-009 result_o  output  2*DATA_W  SHALL be {remainder, quotient}, registered, so EX writes Hi=remainder and Lo=quotient.
REQ-010 ready_o  output  1  SHALL flag result_o valid, registered.

Function
REQ-011 The state machine SHALL have states IDLE, BYZERO, ON and END, and SHALL leave reset in IDLE.
REQ-012 IDLE, start_i=1, annul_i=0 SHALL capture the operands and signed_i, clear the 6-bit counter, and go to ON; with DIV_ZERO_FAST_EN defined and opdata2_i=0 it SHALL go to BYZERO instead.
REQ-013 Operand or signed_i changes after the capture edge SHALL be ignored.
REQ-014 Signed capture SHALL store magnitudes |op1| and |op2| (two's-complement negate if MSB=1), quotient sign op1[MSB]^op2[MSB], and remainder sign op1[MSB].
REQ-015 ON SHALL perform one restoring step per cycle: shift {partial remainder, dividend} left 1; if the partial remainder ≥ divisor, subtract and set the quotient LSB to 1, else set it to 0.
REQ-016 ON SHALL go to END on the step with counter=DATA_W-1, registering sign-corrected results into result_o and setting ready_o=1.
REQ-017 Latency SHALL be: ready_o is high after the (DATA_W+1)th rising edge, counting the IDLE capture edge as the 1st (33 edges for DATA_W=32).
REQ-018 END SHALL hold ready_o=1 and result_o stable while start_i=1; start_i=0 SHALL go to IDLE and clear ready_o on the next edge. result_o SHALL keep its last value in IDLE.
REQ-019 annul_i=1 in ON, BYZERO or END SHALL go to IDLE on the next edge with ready_o=0; annul_i together with start_i in IDLE SHALL keep the block in IDLE (annul wins).
REQ-020 start_i falling during ON or BYZERO SHALL be ignored; only annul_i aborts.
REQ-021 Signed -2^(DATA_W-1)/-1 SHALL give quotient 0x80000000 and remainder 0 with no flag.
REQ-022 ready_o SHALL never be high in IDLE, ON or BYZERO.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, counter=0, ready_o=0, result_o=0 and the internal operand registers to 0, including mid-division.
REQ-024 rst SHALL take priority over start_i and annul_i.

Configuration
REQ-025 With macro DIV_ZERO_FAST_EN defined, divisor=0 SHALL go IDLE→BYZERO→END in 2 edges with result_o=0 and ready_o=1.
REQ-026 Without DIV_ZERO_FAST_EN, divisor=0 SHALL take the full ON path, giving the raw restoring result with sign correction (unsigned: quotient 0xFFFFFFFF, remainder = dividend); BYZERO SHALL not exist.

Verification
REQ-027 Unsigned 100/7, start held -> ready_o after edge 33, result_o={0x00000002,0x0000000E}; start drops -> ready_o=0 next edge.
REQ-028 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-029 Signed 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}; unsigned same operands -> {0x80000000,0x00000000}.
REQ-030 Unsigned 5/0 -> with DIV_ZERO_FAST_EN: ready after 2 edges, result 0; without: ready after 33 edges, {0x00000005,0xFFFFFFFF}.
REQ-031 annul_i pulsed at step 10 -> IDLE next edge, ready_o never asserts; a new 9/3 immediately after -> {0,3} after 33 edges.
REQ-032 rst asserted at step 20 -> all outputs 0 next edge; operands changed mid-ON -> result reflects the captured operands only.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per clock.
// Signed operands are converted to magnitudes at capture and the signs are
// re-applied on the last step; result_o is {remainder, quotient}.
// Optional feature macro: DIV_ZERO_FAST_EN -- when defined, a zero divisor
// skips the iteration through the BYZERO state and returns an all-zero result.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam logic [5:0]        CNT_LAST = 6'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;
`endif

    state_t state_reg;
    state_t state_next;

    logic [5:0]          cnt_reg;
    logic [DATA_W-1:0]   dividend_reg;   // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   divisor_reg;
    logic [DATA_W-1:0]   rem_reg;        // partial remainder
    logic                quo_neg_reg;
    logic                rem_neg_reg;
    logic [2*DATA_W-1:0] result_reg;
    logic                ready_reg;

    // control strobes decoded from the current state
    logic capture;
    logic step;
    logic finish;
    logic zero_result;
    logic ready_next;

    // datapath combinational values
    logic                op1_neg;
    logic                op2_neg;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [DATA_W:0]     shifted;
    logic                ge;
    logic [DATA_W-1:0]   new_rem;
    logic [DATA_W-1:0]   q_step;
    logic [DATA_W-1:0]   q_final;
    logic [DATA_W-1:0]   r_final;

    // state register; reset overrides every request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state logic; annul_i always wins, a falling start_i only matters in END
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i && !annul_i) begin
`ifdef DIV_ZERO_FAST_EN
                    state_next = (opdata2_i == '0) ? BYZERO : ON;
`else
                    state_next = ON;
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            BYZERO: begin
                state_next = annul_i ? IDLE : END;
            end
`endif
            ON: begin
                if (annul_i) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = END;
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // output decode: datapath strobes, and ready follows entry into / stay in END
    always_comb begin
        capture     = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        zero_result = 1'b0;
        case (state_reg)
            IDLE: capture = start_i && !annul_i;
`ifdef DIV_ZERO_FAST_EN
            BYZERO: zero_result = !annul_i;
`endif
            ON: begin
                step   = !annul_i;
                finish = !annul_i && (cnt_reg == CNT_LAST);
            end
            default: ;
        endcase
        ready_next = (state_next == END);
    end

    // operand magnitudes, one restoring step and final sign correction
    always_comb begin
        op1_neg = signed_i && opdata1_i[DATA_W-1];
        op2_neg = signed_i && opdata2_i[DATA_W-1];
        mag1    = op1_neg ? (~opdata1_i + ONE) : opdata1_i;
        mag2    = op2_neg ? (~opdata2_i + ONE) : opdata2_i;

        shifted = {rem_reg, dividend_reg[DATA_W-1]};
        // the top bit set means the shifted remainder already exceeds any divisor
        ge      = shifted[DATA_W] || (shifted[DATA_W-1:0] >= divisor_reg);
        new_rem = ge ? (shifted[DATA_W-1:0] - divisor_reg) : shifted[DATA_W-1:0];
        q_step  = {dividend_reg[DATA_W-2:0], ge};

        q_final = quo_neg_reg ? (~q_step + ONE) : q_step;
        r_final = rem_neg_reg ? (~new_rem + ONE) : new_rem;
    end

    // datapath registers: capture, iterate, and latch the finished result
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quo_neg_reg  <= 1'b0;
            rem_neg_reg  <= 1'b0;
            result_reg   <= '0;
            ready_reg    <= 1'b0;
        end else begin
            ready_reg <= ready_next;
            if (capture) begin
                cnt_reg      <= '0;
                dividend_reg <= mag1;
                divisor_reg  <= mag2;
                rem_reg      <= '0;
                quo_neg_reg  <= op1_neg ^ op2_neg;
                rem_neg_reg  <= op1_neg;
            end else if (step) begin
                cnt_reg      <= cnt_reg + 6'd1;
                dividend_reg <= q_step;
                rem_reg      <= new_rem;
            end
            if (finish) begin
                result_reg <= {r_final, q_final};
            end else if (zero_result) begin
                result_reg <= '0;
            end
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit with a result scoreboard.
// Expected results are queued when a division is issued and popped when
// ready_o is observed. Outputs are sampled 1 time unit after each rising edge.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    int          tests;
    int          fails;
    logic [63:0] exp_q[$];

    div_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // reference division using the simulator's own arithmetic
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // issue one division, measure latency, check the result, the hold phase and the release
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int exp_edges, input bit annul_end);
        int          edges;
        logic [63:0] exp_r;
        exp_q.push_back(exp);
        annul_i   = 1'b0;
        opdata1_i = a;
        opdata2_i = b;
        signed_i  = s;
        start_i   = 1'b1;
        tick();
        edges = 1;
        check("ready_after_capture", 64'(ready_o), 64'd0);
        // operands and mode must be ignored once captured
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~s;
        while (!ready_o && edges < 40) begin
            tick();
            edges++;
        end
        exp_r = exp_q.pop_front();
        $display("[TB] div a=%h b=%h signed=%0d -> result=%h ready_edge=%0d", a, b, s, result_o, edges);
        check("latency_edges", 64'(edges), 64'(exp_edges));
        check("result", result_o, exp_r);
        tick();
        check("hold_ready", 64'(ready_o), 64'd1);
        check("hold_result", result_o, exp_r);
        if (annul_end) annul_i = 1'b1;
        else start_i = 1'b0;
        tick();
        check("release_ready", 64'(ready_o), 64'd0);
        check("idle_result_kept", result_o, exp_r);
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        bit          ready_seen;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (3) tick();
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", 64'(ready_o), 64'd0);

        // basic unsigned and signed cases
        do_div(32'd100, 32'd7, 1'b0, {32'h00000002, 32'h0000000E}, 33, 1'b0);
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
        do_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, 1'b0);
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33, 1'b0);
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h00000000}, 33, 1'b1);

        // divide by zero
`ifdef DIV_ZERO_FAST_EN
        do_div(32'd5, 32'd0, 1'b0, 64'd0, 2, 1'b0);
`else
        do_div(32'd5, 32'd0, 1'b0, {32'h00000005, 32'hFFFFFFFF}, 33, 1'b0);
`endif

        // annul mid-division, then an immediate new request
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        signed_i  = 1'b0;
        start_i   = 1'b1;
        tick();
        ready_seen = 1'b0;
        repeat (10) begin
            tick();
            ready_seen = ready_seen | ready_o;
        end
        annul_i = 1'b1;
        tick();
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_no_early_ready", 64'(ready_seen), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        do_div(32'd9, 32'd3, 1'b0, {32'h00000000, 32'h00000003}, 33, 1'b0);

        // annul together with start in IDLE must not begin a division
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) tick();
        check("annul_wins_idle", 64'(ready_o), 64'd0);
        do_div(32'd1234567, 32'd89, 1'b0, model(32'd1234567, 32'd89, 1'b0), 33, 1'b0);

        // reset in the middle of a division
        opdata1_i = 32'h12345678;
        opdata2_i = 32'h00001234;
        start_i   = 1'b1;
        tick();
        repeat (19) tick();
        rst = 1'b1;
        tick();
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        tick();
        check("rst_over_start", 64'(ready_o), 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        tick();
        check("post_rst_idle", 64'(ready_o), 64'd0);

        // random operands against the reference model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
            rs = 1'($urandom_range(0, 1));
            if (rb == 32'd0) rb = 32'd1;
            if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            do_div(ra, rb, rs, model(ra, rb, rs), 33, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
